// File: rtl/sha256_xmss_pkg.sv
// Shared constants, types and helpers for the multi-block XMSS SHA-256 front-end.
package sha256_xmss_pkg;

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] SHA256_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {IDLE, WAIT, RUN, FIN} state_t;

    // Parameters of one hash, captured when start is accepted.
    typedef struct packed {
        logic [7:0]  words;     // effective message length in 256-bit words
        logic [7:0]  n_blk;     // number of 512-bit blocks incl. padding
        logic [63:0] bit_len;   // length field placed in the final block
        logic        init_iv;
        logic        use_saved; // chain block 0 from the saved state
        logic        store;     // save chaining value after block 0
    } job_t;

    // Blocks needed for a message of msg_words 256-bit words.
    function automatic int nblk(input int msg_words);
        if (msg_words % 2 == 0) return msg_words / 2 + 1;
        return (msg_words + 1) / 2;
    endfunction

    // Block k of the padded message; w_lo/w_hi are data words 2k and 2k+1.
    function automatic logic [511:0] pad_block(input logic [255:0] w_lo,
                                               input logic [255:0] w_hi,
                                               input int words, input int k,
                                               input logic [63:0] len);
        if (2 * k + 2 <= words) return {w_lo, w_hi};
        if (2 * k + 1 == words) return {w_lo, 8'h80, 184'd0, len};
        return {8'h80, 440'd0, len};
    endfunction

endpackage

// File: rtl/sha256_xmss_core.sv
// Single SHA-256 compression, one round per clock, with Davies-Meyer feed-forward.
// start at cycle s -> done pulse (chain_out valid, then held) at cycle s+66.
module sha256_xmss_core
    import sha256_xmss_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] chain_in,
    input  logic [511:0] block_in,
    output logic [255:0] chain_out,
    output logic         done
);

    logic [7:0][31:0]  chain_q;  // [7] = H0
    logic [7:0][31:0]  ws;       // working vars, [7] = a ... [0] = h
    logic [15:0][31:0] w_q;      // schedule window, [0] = W_t
    logic [5:0]        rnd_q;
    logic              run_q;
    logic              ff_q;

    logic [31:0] t1, t2, w_new;
    logic [7:0][31:0] ff_sum;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Round function, next schedule word and feed-forward sum.
    always_comb begin
        t1 = ws[0] + (rotr(ws[3], 6) ^ rotr(ws[3], 11) ^ rotr(ws[3], 25))
           + ((ws[3] & ws[2]) ^ (~ws[3] & ws[1])) + SHA256_K[rnd_q] + w_q[0];
        t2 = (rotr(ws[7], 2) ^ rotr(ws[7], 13) ^ rotr(ws[7], 22))
           + ((ws[7] & ws[6]) ^ (ws[7] & ws[5]) ^ (ws[6] & ws[5]));
        w_new = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
              + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
        for (int i = 0; i < 8; i++) ff_sum[i] = chain_q[i] + ws[i];
    end

    // Load on start, iterate 64 rounds, then one cycle for the feed-forward.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q     <= 1'b0;
            ff_q      <= 1'b0;
            done      <= 1'b0;
            rnd_q     <= '0;
            chain_out <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                chain_q <= chain_in;
                ws      <= chain_in;
                for (int i = 0; i < 16; i++) w_q[i] <= block_in[511 - 32*i -: 32];
                rnd_q   <= '0;
                run_q   <= 1'b1;
                ff_q    <= 1'b0;
            end else if (run_q) begin
                ws    <= {t1 + t2, ws[7], ws[6], ws[5], ws[4] + t1, ws[3], ws[2], ws[1]};
                w_q   <= {w_new, w_q[15:1]};
                rnd_q <= rnd_q + 6'd1;
                if (rnd_q == 6'd63) begin
                    run_q <= 1'b0;
                    ff_q  <= 1'b1;
                end
            end else if (ff_q) begin
                ff_q      <= 1'b0;
                done      <= 1'b1;
                chain_out <= ff_sum;
            end
        end
    end

endmodule

// File: rtl/sha256_xmss_multiblock.sv
// XMSS hash front-end: pads a 1..MAX_WORDS word message and sequences its
// 512-bit blocks through one compression core, gating each data block on
// words_avail. Optional saved-state feature: define SHA256_XMSS_STORE_EN.
module sha256_xmss_multiblock
    import sha256_xmss_pkg::*;
#(
    parameter int MAX_WORDS = 4,
    parameter int LEN_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     init_iv,
    input  logic [LEN_W-1:0]         msg_words,
    input  logic [LEN_W-1:0]         words_avail,
    input  logic [MAX_WORDS*256-1:0] data_in,
    input  logic                     store_intermediate,
    input  logic                     continue_intermediate,
    output logic [255:0]             data_out,
    output logic                     data_out_valid,
    output logic                     done,
    output logic                     busy
);

    localparam int NBLK_MAX = MAX_WORDS / 2 + 1;
    localparam int BLK_W    = $clog2(NBLK_MAX + 1);

    state_t            state_q, state_d;
    job_t              job_q, job_nx;
    logic [BLK_W-1:0]  blk_q;
    logic              core_start, core_done;
    logic [255:0]      core_chain, chain_sel;
    logic [255:0]      w_lo, w_hi;
    logic [511:0]      block;
    logic              avail_ok, last_blk;
    logic [255:0]      saved_chain;
    logic              saved_vld;

`ifdef SHA256_XMSS_STORE_EN
    logic [255:0] saved_q;
    logic         saved_vld_q;

    // Capture the chaining value after block 0 of a storing hash.
    always_ff @(posedge clk) begin
        if (reset) begin
            saved_q     <= '0;
            saved_vld_q <= 1'b0;
        end else if (state_q == RUN && core_done && blk_q == '0 && job_q.store) begin
            saved_q     <= core_chain;
            saved_vld_q <= 1'b1;
        end
    end

    assign saved_chain = saved_q;
    assign saved_vld   = saved_vld_q;
`else
    logic unused_cfg;
    assign unused_cfg  = store_intermediate ^ continue_intermediate ^ job_q.store ^ job_q.use_saved;
    assign saved_chain = '0;
    assign saved_vld   = 1'b0;
`endif

    // Decode the job at start: clamp length, pick chaining source, length field.
    always_comb begin
        int  mw;
        logic cont;
        mw = int'(msg_words);
        if (mw == 0 || mw > MAX_WORDS) mw = MAX_WORDS;
        cont = continue_intermediate && saved_vld;
        job_nx           = '0;
        job_nx.words     = 8'(mw);
        job_nx.n_blk     = 8'(nblk(mw));
        job_nx.bit_len   = 64'(cont ? mw + 2 : mw) << 8;
        job_nx.init_iv   = init_iv;
        job_nx.use_saved = cont;
        job_nx.store     = store_intermediate && !continue_intermediate && (saved_vld || !saved_vld);
    end

    // Pick data words 2k and 2k+1 for the current block.
    always_comb begin
        w_lo = '0;
        w_hi = '0;
        for (int i = 0; i < MAX_WORDS; i++) begin
            if (i == 2 * int'(blk_q))     w_lo = data_in[256*i +: 256];
            if (i == 2 * int'(blk_q) + 1) w_hi = data_in[256*i +: 256];
        end
    end

    assign block = pad_block(w_lo, w_hi, int'(job_q.words), int'(blk_q), job_q.bit_len);

    // Block k may start once its words are present; the pure-padding block never waits.
    always_comb begin
        int need;
        need = 2 * int'(blk_q) + 2;
        if (need > int'(job_q.words)) need = int'(job_q.words);
        avail_ok = (2 * int'(blk_q) >= int'(job_q.words)) || (int'(words_avail) >= need);
        last_blk = (int'(blk_q) == int'(job_q.n_blk) - 1);
    end

    // Block 0 chains from saved state, IV or zero; later blocks from the core.
    always_comb begin
        if (blk_q != '0)          chain_sel = core_chain;
        else if (job_q.use_saved) chain_sel = saved_chain;
        else if (job_q.init_iv)   chain_sel = SHA256_IV;
        else                      chain_sel = '0;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start)     state_d = WAIT;
            WAIT: if (avail_ok)  state_d = RUN;
            RUN:  if (core_done) state_d = last_blk ? FIN : WAIT;
            FIN:                 state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // Job capture, block counter, core issue and digest register.
    always_ff @(posedge clk) begin
        if (reset) begin
            job_q          <= '0;
            blk_q          <= '0;
            core_start     <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            core_start <= (state_q == WAIT) && avail_ok;
            if (state_q == IDLE && start) begin
                job_q          <= job_nx;
                blk_q          <= '0;
                data_out_valid <= 1'b0;
            end
            if (state_q == RUN && core_done) begin
                if (last_blk) begin
                    data_out       <= core_chain;
                    data_out_valid <= 1'b1;
                end else begin
                    blk_q <= blk_q + 1'b1;
                end
            end
        end
    end

    assign done = (state_q == FIN);
    assign busy = (state_q != IDLE);

    sha256_xmss_core u_core (
        .clk      (clk),
        .reset    (reset),
        .start    (core_start),
        .chain_in (chain_sel),
        .block_in (block),
        .chain_out(core_chain),
        .done     (core_done)
    );

endmodule

// File: tb/tb_sha256_xmss_multiblock.sv
// Directed bench for sha256_xmss_multiblock against an independent SHA-256 model.
module tb_sha256_xmss_multiblock;

    localparam int MW = 4;
    localparam int LW = $clog2(MW + 1);
    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam bit [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              init_iv = 1'b1;
    logic [LW-1:0]     msg_words = '0;
    logic [LW-1:0]     words_avail = '0;
    logic [MW*256-1:0] data_in = '0;
    logic              store_intermediate = 1'b0;
    logic              continue_intermediate = 1'b0;
    logic [255:0]      data_out;
    logic              data_out_valid, done, busy;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_starts = 0;
    int n_dones = 0;

    sha256_xmss_multiblock #(.MAX_WORDS(MW)) dut (
        .clk(clk), .reset(reset), .start(start), .init_iv(init_iv),
        .msg_words(msg_words), .words_avail(words_avail), .data_in(data_in),
        .store_intermediate(store_intermediate), .continue_intermediate(continue_intermediate),
        .data_out(data_out), .data_out_valid(data_out_valid), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (dut.core_start) n_starts <= n_starts + 1;
        if (done)           n_dones  <= n_dones + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t, want finish", $time);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] s [8];
        logic [31:0] t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        for (int i = 0; i < 8; i++) s[i] = hin[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = s[7] + (rr(s[4], 6) ^ rr(s[4], 11) ^ rr(s[4], 25))
               + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KT[t] + w[t];
            t2 = (rr(s[0], 2) ^ rr(s[0], 13) ^ rr(s[0], 22))
               + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
            s[7] = s[6]; s[6] = s[5]; s[5] = s[4]; s[4] = s[3] + t1;
            s[3] = s[2]; s[2] = s[1]; s[1] = s[0]; s[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + s[i];
        return r;
    endfunction

    // Byte-level FIPS 180-4 padding of the first n words, then chained compressions.
    function automatic logic [255:0] model(input logic [MW*256-1:0] d, input int n, input logic [255:0] iv);
        byte unsigned m [$];
        logic [63:0]  bl;
        logic [511:0] blk;
        logic [255:0] h;
        for (int w = 0; w < n; w++)
            for (int b = 0; b < 32; b++) m.push_back(d[w*256 + 255 - 8*b -: 8]);
        bl = 64'(n) * 64'd256;
        m.push_back(8'h80);
        while (m.size() % 64 != 56) m.push_back(8'h00);
        for (int i = 0; i < 8; i++) m.push_back(bl[63 - 8*i -: 8]);
        h = iv;
        for (int k = 0; k < m.size() / 64; k++) begin
            for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = m[64*k + j];
            h = compress(h, blk);
        end
        return h;
    endfunction

    function automatic logic [MW*256-1:0] fill(input int seed);
        logic [MW*256-1:0] d;
        d = '0;
        if (seed != 0)
            for (int w = 0; w < MW; w++)
                for (int b = 0; b < 32; b++) d[w*256 + 255 - 8*b -: 8] = 8'(seed * 37 + w * 32 + b);
        return d;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input int mw, input int avail, input bit iv, input bit st,
                               input bit ct, input logic [MW*256-1:0] d);
        @(posedge clk); #1;
        msg_words = LW'(mw); words_avail = LW'(avail); init_iv = iv;
        store_intermediate = st; continue_intermediate = ct; data_in = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, output logic [255:0] dig);
        bit ok;
        ok = 1'b0;
        dig = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; dig = data_out; break; end
        end
        chk({name, "_done_seen"}, 256'(ok), 256'd1);
    endtask

    typedef struct {
        int           mw;
        int           avail;
        bit           iv;
        int           seed;
        bit           use_exp;
        logic [255:0] exp;
    } vec_t;

    vec_t vt [7];

    initial begin
        logic [255:0]      dig, dig1, expd;
        logic [MW*256-1:0] d;
        int s0, d0, eff, rc, sc, nb;
        bit held;

        vt[0] = '{1, 1, 1'b1, 0, 1'b1, 256'h66687aadf862bd776c8fc18b8e9f8e20089714856ee233b3902a591d0d5f2925};
        vt[1] = '{2, 2, 1'b1, 0, 1'b1, 256'hf5a5fd42d16a20302798ef6ed309979b43003d2320d9f0e8ea9831a92759fb4b};
        vt[2] = '{3, 3, 1'b1, 1, 1'b0, '0};
        vt[3] = '{4, 4, 1'b1, 2, 1'b0, '0};
        vt[4] = '{1, 1, 1'b1, 3, 1'b0, '0};
        vt[5] = '{2, 2, 1'b0, 4, 1'b0, '0};
        vt[6] = '{0, 4, 1'b1, 5, 1'b0, '0};

        // reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_done", 256'(done), 256'd0);
        chk("rst_valid", 256'(data_out_valid), 256'd0);
        chk("rst_data", data_out, 256'd0);

        // table vectors
        foreach (vt[i]) begin
            d    = fill(vt[i].seed);
            eff  = (vt[i].mw == 0 || vt[i].mw > MW) ? MW : vt[i].mw;
            nb   = (eff % 2 == 1) ? (eff + 1) / 2 : eff / 2 + 1;
            expd = vt[i].use_exp ? vt[i].exp : model(d, eff, vt[i].iv ? IV : 256'd0);
            s0 = n_starts; d0 = n_dones;
            pulse_start(vt[i].mw, vt[i].avail, vt[i].iv, 1'b0, 1'b0, d);
            wait_done($sformatf("vec%0d", i), dig);
            chk($sformatf("vec%0d_digest", i), dig, expd);
            chk($sformatf("vec%0d_valid", i), 256'(data_out_valid), 256'd1);
            @(negedge clk);
            chk($sformatf("vec%0d_busy_after", i), 256'(busy), 256'd0);
            chk($sformatf("vec%0d_blocks", i), 256'(n_starts - s0), 256'(nb));
            chk($sformatf("vec%0d_done_pulses", i), 256'(n_dones - d0), 256'd1);
        end

        // block 1 gated by words_avail, released exactly one cycle after the raise
        d = fill(9);
        s0 = n_starts;
        pulse_start(4, 2, 1'b1, 1'b0, 1'b0, d);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (dut.core_done) break;
        end
        repeat (40) @(posedge clk);
        chk("gate_stalled_starts", 256'(n_starts - s0), 256'd1);
        #1 words_avail = LW'(4);
        rc = cyc; sc = -1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (dut.core_start) begin sc = cyc; break; end
        end
        chk("gate_blk1_start_cycle", 256'(sc), 256'(rc + 1));
        wait_done("gate", dig);
        chk("gate_digest", dig, model(d, 4, IV));
        @(negedge clk);
        chk("gate_blocks", 256'(n_starts - s0), 256'd3);

        // start during RUN ignored
        d = fill(6);
        s0 = n_starts; d0 = n_dones;
        pulse_start(3, 3, 1'b1, 1'b0, 1'b0, d);
        repeat (10) @(posedge clk);
        #1 msg_words = LW'(1); init_iv = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done("ign", dig);
        chk("ign_digest", dig, model(d, 3, IV));
        @(negedge clk);
        chk("ign_blocks", 256'(n_starts - s0), 256'd2);
        chk("ign_done_pulses", 256'(n_dones - d0), 256'd1);

        // back-to-back: second start in the cycle after done
        d = fill(7);
        pulse_start(2, 2, 1'b1, 1'b0, 1'b0, d);
        wait_done("b2b1", dig1);
        chk("b2b1_digest", dig1, model(d, 2, IV));
        d = fill(8);
        @(posedge clk); #1;
        msg_words = LW'(3); words_avail = LW'(3); init_iv = 1'b1; data_in = d; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("b2b_valid_drop", 256'(data_out_valid), 256'd0);
        held = 1'b1;
        dig = '0;
        for (int c = 0; c < 3000; c++) begin
            if (done) begin dig = data_out; break; end
            if (data_out !== dig1) held = 1'b0;
            @(negedge clk);
        end
        chk("b2b_hold_first", 256'(held), 256'd1);
        chk("b2b2_digest", dig, model(d, 3, IV));

`ifdef SHA256_XMSS_STORE_EN
        // store after block 0, continue from it, then fallback after reset
        d = fill(11);
        pulse_start(4, 4, 1'b1, 1'b1, 1'b0, d);
        wait_done("st", dig);
        chk("st_saved", dut.saved_q, compress(IV, {d[255:0], d[511:256]}));
        chk("st_digest", dig, model(d, 4, IV));
        pulse_start(2, 2, 1'b1, 1'b0, 1'b1, {512'd0, d[1023:512]});
        wait_done("cont", dig);
        chk("cont_digest", dig, model(d, 4, IV));
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        pulse_start(2, 2, 1'b1, 1'b0, 1'b1, {512'd0, d[1023:512]});
        wait_done("fb", dig);
        chk("fb_digest", dig, model({512'd0, d[1023:512]}, 2, IV));
`endif

        // reset while RUN aborts the hash
        d = fill(10);
        pulse_start(4, 4, 1'b1, 1'b0, 1'b0, d);
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", 256'(busy), 256'd0);
        chk("abort_done", 256'(done), 256'd0);
        chk("abort_valid", 256'(data_out_valid), 256'd0);
        chk("abort_data", data_out, 256'd0);
        #1 reset = 1'b0;
        d0 = n_dones;
        repeat (300) @(posedge clk);
        @(negedge clk);
        chk("abort_no_done", 256'(n_dones - d0), 256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
